// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and sizing helper for the serial adder
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Bit-position counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    return (cw < 1) ? 1 : cw;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - single-bit combinational full adder
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with start and valid/ready handshakes
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_nx;
  logic             carry;
  logic [CW-1:0]    count;
  logic             s, co, last;

  full_adder_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  assign last = (count == LAST);

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    sum_nx             = sum >> 1;
    sum_nx[WIDTH-1]    = s;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = SHIFT;
      end
      SHIFT: if (last) state_nx = HOLD;
      HOLD:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= co;
          sum   <= sum_nx;
          if (last) begin
            out_valid <= 1'b1;
            cout      <= co;
          end else begin
            count <= count + CW'(1);
          end
        end
        HOLD: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder. It is the additive counterpart of the team's combinational full_subtractor.
- It accepts two operands and a carry-in through a start handshake.
- It adds them LSB-first, one bit per clock, using a single full-adder cell and a registered carry.
- It presents sum and carry-out through a valid/ready output handshake. It serves as the low-area arithmetic primitive for the datapath.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be at least 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition. Sampled only in IDLE.
- a  input  WIDTH  operand A. Captured on the edge that accepts start.
- b  input  WIDTH  operand B. Captured on the edge that accepts start.
- cin  input  1  carry-in. Captured with the operands.
- busy  output  1  high whenever state is not IDLE.
- out_valid  output  1  result is available on sum/cout.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry-out.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE; busy=0, out_valid=0, sum=0, cout=0; internal shift registers, carry and counter all cleared.
- States:
  - IDLE: busy=0. If start=1 at an edge:
    - load shift registers A←a, B←b; carry←cin; count←0.
    - go to SHIFT. This is the "accept edge".
  - SHIFT: busy=1. Each edge:
    - (s,co) = full_adder_cell(A[0], B[0], carry).
    - sum register shifts right with s inserted at the MSB.
    - carry←co; A and B shift right; count←count+1.
    - On the edge where count==WIDTH-1: go to HOLD, set out_valid←1, cout←co.
  - HOLD: busy=1, out_valid=1. sum and cout are held stable.
    - If out_ready=1 at an edge: go to IDLE, out_valid←0.
    - sum and cout keep their last values after leaving HOLD (not cleared).
- Latency:
  - out_valid rises after exactly WIDTH edges following the accept edge.
  - For WIDTH=1, that is the next edge.
- Start handling:
  - start is ignored in SHIFT and HOLD. No queueing.
  - start and out_ready both high in HOLD: only the release is taken; start is not accepted that edge.
  - Minimum accept-to-accept spacing is therefore WIDTH+2 edges.
- Arithmetic:
  - {cout,sum} = a + b + cin, exact, modulo 2^(WIDTH+1). No overflow flag.
- Input stability:
  - a, b and cin are ignored except on the accept edge. Changing them mid-operation has no effect.
- Counter: width max(1, clog2(WIDTH)). No wrap occurs beyond WIDTH-1.
- Reset mid-operation (SHIFT or HOLD): operation is aborted, no result is produced, and all outputs take their reset values.
- out_ready outside HOLD: no effect.

Decomposition:
- Package serial_arith_pkg holds:
  - the state enum (IDLE, SHIFT, HOLD), 2-bit encoding;
  - a count-width function.
- One sub-module, full_adder_cell (inputs a, b, ci; outputs s, co; purely combinational).
  - s = a^b^ci.
  - co = a&b | a&ci | b&ci.
  - It is instantiated once.
- The sequential logic lives entirely in serial_adder.

Test Plan:
- Basic add: WIDTH=8, a=0x35, b=0x4A, cin=0, out_ready=1 → out_valid after 8 edges; sum=0x7F, cout=0; busy falls the following edge.
- Carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Busy rejection: start 0x10+0x20, then pulse start with a=0xAA during SHIFT and during HOLD → result 0x30, cout=0; no second result; busy stays high until release.
- Backpressure: out_ready=0 for 5 cycles after out_valid → sum/cout/out_valid stable throughout. Raise out_ready with start=1 the same cycle → IDLE next edge, start not accepted.
- Reset mid-op: assert rst_n=0 at SHIFT count=3 → busy, out_valid, sum and cout read 0 immediately. After release, a new start 0x01+0x01 → sum=0x02.
- Edge width and exhaustive check: WIDTH=1, all 8 (a,b,cin) combinations → out_valid one edge after accept; {cout,sum} matches a+b+cin. Run a random 1000-vector regression at WIDTH=8 against a golden model.
